mte_auth_decrypt: RTL
=====================

# mte_auth_decrypt

Receive-side companion of the MTE encrypt path. Accepts one ciphertext frame (cipher word, authentication tag, key) per valid/ready handshake and recovers the plaintext with an iterative inverse cipher, one round per clock. It then checks the tag and returns the plaintext plus a pass/fail flag through a second valid/ready handshake. It sits between the link/receive buffer and the consumer of decrypted data, and keeps a saturating count of authentication failures.

## Interface
- N, default 8: data/key/tag width in bits; must be even and ≥ 4.
- ROUNDS, default 4: number of cipher rounds; must be ≥ 1.

- clock  input  1  sole clock, rising-edge.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  frame present on in_cipher/in_tag/in_key.
- in_ready  output  1  block can accept a frame.
- in_cipher  input  N  ciphertext word.
- in_tag  input  N  received authentication tag.
- in_key  input  N  key for this frame.
- out_valid  output  1  result present on out_data/out_mac_ok.
- out_ready  input  1  consumer accepts the result.
- out_data  output  N  recovered plaintext; all-zero when authentication fails.
- out_mac_ok  output  1  1 = tag matched.
- fail_count  output  8  number of failed frames, saturates at 255.

## Operation
- Definitions:
  - rotl/rotr are N-bit rotates.
  - Round key k_r = rotl(key, r mod N) for r = 0..ROUNDS-1.
- Encrypt direction, defining the format: x ← rotl(x ^ k_r, 1) for r = 0..ROUNDS-1. The ciphertext is the final x.
- Decrypt, this block: y ← rotr(y, 1) ^ k_r for r = ROUNDS-1 down to 0.
- Tag: expected = plaintext ^ rotl(key, N/2). out_mac_ok = (expected == in_tag).
- The tag is sent in clear.
- FSM states:
  - IDLE: in_ready = 1. When in_valid is high, register in_cipher, in_tag and in_key, load round counter = ROUNDS-1, and go to ROUND. in_valid low stays in IDLE.
  - ROUND: each cycle, apply one inverse round using counter r, then decrement.
    - When the round with r = 0 completes, register out_data, out_mac_ok and fail_count in the same edge, and go to DONE.
    - out_data = plaintext if the tag matches, else 0.
    - fail_count increments on a mismatch, saturating at 255.
  - DONE: out_valid = 1, and out_data/out_mac_ok are held stable. When out_ready is high, go to IDLE and drop out_valid. Otherwise stay in DONE.
- in_ready is 0 in ROUND and DONE. Input pins are ignored outside IDLE, so input changes mid-frame do not affect the frame in flight.
- Reset, at any time including mid-frame:
  - State returns to IDLE and the frame in flight is discarded.
  - Outputs: out_valid = 0, out_data = 0, out_mac_ok = 0, fail_count = 0, in_ready = 1.
- fail_count is cleared only by reset.

## Timing
- Accept edge T: the edge where in_valid and in_ready are both high.
- Rounds execute on edges T+1 … T+ROUNDS. out_valid rises after edge T+ROUNDS, so latency is ROUNDS cycles from the accept edge.
- With out_ready held high:
  - Output handshake at edge T+ROUNDS+1.
  - in_ready returns high in the following cycle.
  - Next accept no earlier than edge T+ROUNDS+2, so peak throughput is one frame per ROUNDS+2 cycles.
- Backpressure: out_valid may stay high indefinitely. Outputs and fail_count do not change while waiting.
- ROUNDS = 1: a single ROUND cycle, then DONE.

## Test plan
1. Reset mid-ROUND, then all-zero frame:
   - Reset mid-ROUND → all outputs at reset values and in_ready = 1 in the next cycle.
   - Then in_key = 0x00, in_cipher = 0x00, in_tag = 0x00 → out_data = 0x00, out_mac_ok = 1, fail_count = 0.
2. in_key = 0x00, in_cipher = 0x10, in_tag = 0x01 → out_data = 0x01, out_mac_ok = 1. out_valid rises exactly 4 cycles after the accept edge.
3. in_key = 0xAA, in_cipher = 0x0F, in_tag = 0x5A → out_data = 0xF0, out_mac_ok = 1.
4. Same frame as 3 with in_tag = 0x5B → out_data = 0x00, out_mac_ok = 0, fail_count = 1.
5. Backpressure on frame 3:
   - out_ready held low for 10 cycles → out_valid and out_data = 0xF0 stable, in_ready = 0, and a new in_valid is ignored.
   - Then out_ready = 1 → IDLE next cycle.
   - Back-to-back frames achieve a period of 6 cycles.
6. 256 consecutive bad-tag frames → fail_count saturates at 255. The next good frame leaves it at 255 with out_mac_ok = 1.

Source files
------------

// File: rtl/mte_auth_decrypt.sv
// Receive-side MTE frame decryptor: iterative inverse cipher (one round per clock),
// tag check, and a saturating authentication-failure counter.
module mte_auth_decrypt #(
    parameter int N      = 8,
    parameter int ROUNDS = 4
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_cipher,
    input  logic [N-1:0] in_tag,
    input  logic [N-1:0] in_key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_data,
    output logic         out_mac_ok,
    output logic [7:0]   fail_count
);

    localparam int CW = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  y_q, y_d;
    logic [N-1:0]  tag_q, tag_d;
    logic [N-1:0]  key_q, key_d;
    logic [CW-1:0] r_q, r_d;
    logic [N-1:0]  data_q, data_d;
    logic          ok_q, ok_d;
    logic [7:0]    fail_q, fail_d;

    logic [N-1:0]  round_key;
    logic [N-1:0]  y_round;
    logic          tag_ok;

    // Rotate amounts are reduced mod N; a zero amount makes the right shift drop everything.
    function automatic logic [N-1:0] rotl_f(input logic [N-1:0] v, input int unsigned s);
        int unsigned m;
        m = s % N;
        return (v << m) | (v >> (N - m));
    endfunction

    assign round_key = rotl_f(key_q, 32'(r_q));
    assign y_round   = {y_q[0], y_q[N-1:1]} ^ round_key;
    assign tag_ok    = ((y_round ^ rotl_f(key_q, N / 2)) == tag_q);

    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        tag_d   = tag_q;
        key_d   = key_q;
        r_d     = r_q;
        data_d  = data_q;
        ok_d    = ok_q;
        fail_d  = fail_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    y_d     = in_cipher;
                    tag_d   = in_tag;
                    key_d   = in_key;
                    r_d     = CW'(ROUNDS - 1);
                    state_d = ROUND;
                end
            end
            ROUND: begin
                y_d = y_round;
                r_d = r_q - CW'(1);
                if (r_q == '0) begin
                    // y_round is the full plaintext on the last inverse round.
                    data_d  = tag_ok ? y_round : '0;
                    ok_d    = tag_ok;
                    if (!tag_ok && fail_q != 8'hFF) begin
                        fail_d = fail_q + 8'd1;
                    end
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            y_q     <= '0;
            tag_q   <= '0;
            key_q   <= '0;
            r_q     <= '0;
            data_q  <= '0;
            ok_q    <= 1'b0;
            fail_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            tag_q   <= tag_d;
            key_q   <= key_d;
            r_q     <= r_d;
            data_q  <= data_d;
            ok_q    <= ok_d;
            fail_q  <= fail_d;
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = (state_q == DONE);
    assign out_data   = data_q;
    assign out_mac_ok = ok_q;
    assign fail_count = fail_q;

endmodule
